// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues credit-limited memory reads and buffers responses for decode.
// Optional feature macro FETCH_HALT_ON_ZERO_EN: issuing a zero instruction halts fetch until a redirect.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic [31:0] instr_reg,
    output logic [63:0] ifid_npc,
    output logic        halted
);
    localparam int unsigned PW     = $clog2(DEPTH);
    localparam int unsigned CW     = PW + 1;
    localparam logic [CW:0] CAP    = DEPTH[CW:0];
    localparam logic [31:0] BUBBLE = 32'h000000FF;

    logic [63:0]   pc_q, pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wr_q, rd_q, aq_wr_q, aq_rd_q;
    logic [31:0]   fifo_data_q [DEPTH];
    logic [63:0]   fifo_npc_q  [DEPTH];
    logic [63:0]   aq_q        [DEPTH];
    logic [31:0]   instr_q, instr_d;
    logic [63:0]   npc_q, npc_d;
    logic          accept, keep, push, pop;

    // Credit covers both in-flight requests and buffered instructions, so the FIFO can never overflow.
    assign mem_req_valid = reset && !halted && (({1'b0, outst_q} + {1'b0, cnt_q}) < CAP);
    assign mem_req_addr  = pc_q;
    assign accept        = mem_req_valid && mem_req_ready;
    assign keep          = mem_resp_valid && (drop_q == '0);
    assign push          = keep && !redirect_valid;
    assign pop           = !redirect_valid && !stall && (cnt_q != '0);
    assign instr_reg     = instr_q;
    assign ifid_npc      = npc_q;

    always_comb begin
        pc_d = pc_q;
        if (accept)
            pc_d = pc_q + 64'd4;
        if (redirect_valid)
            pc_d = redirect_pc;

        outst_d = outst_q + CW'(accept) - CW'(mem_resp_valid);

        drop_d = drop_q;
        if (mem_resp_valid && (drop_q != '0))
            drop_d = drop_q - CW'(1);
        if (redirect_valid)
            drop_d = outst_d;

        cnt_d = redirect_valid ? '0 : (cnt_q + CW'(push) - CW'(pop));

        instr_d = instr_q;
        npc_d   = npc_q;
        if (redirect_valid) begin
            instr_d = BUBBLE;
        end else if (!stall) begin
            if (pop) begin
                instr_d = fifo_data_q[rd_q];
                npc_d   = fifo_npc_q[rd_q];
            end else begin
                instr_d = BUBBLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            aq_wr_q <= '0;
            aq_rd_q <= '0;
            instr_q <= BUBBLE;
            npc_q   <= RESET_PC;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
            if (redirect_valid) begin
                wr_q    <= '0;
                rd_q    <= '0;
                aq_wr_q <= '0;
                aq_rd_q <= '0;
            end else begin
                if (push)   wr_q    <= wr_q + PW'(1);
                if (pop)    rd_q    <= rd_q + PW'(1);
                if (accept) aq_wr_q <= aq_wr_q + PW'(1);
                if (keep)   aq_rd_q <= aq_rd_q + PW'(1);
            end
        end
    end

    // Storage arrays carry no reset; the pointers above define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_q] <= mem_resp_data;
            fifo_npc_q[wr_q]  <= aq_q[aq_rd_q] + 64'd4;
        end
        if (accept && !redirect_valid)
            aq_q[aq_wr_q] <= pc_q;
    end

`ifdef FETCH_HALT_ON_ZERO_EN
    logic halt_q, halt_d;

    always_comb begin
        halt_d = halt_q;
        if (redirect_valid)
            halt_d = 1'b0;
        else if (pop && (fifo_data_q[rd_q] == '0))
            halt_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            halt_q <= 1'b0;
        else
            halt_q <= halt_d;
    end

    assign halted = halt_q;
`else
    assign halted = 1'b0;
`endif

endmodule
